// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the pipelined core.
// Owns the PC register, issues reads to a synchronous-read instruction BRAM
// and presents the IF/ID payload (pc, pc+4, instruction, valid) to decode.
// Redirects from the next-PC unit kill wrong-path fetches; hazard stalls
// freeze the PC and IF/ID while the BRAM output is captured in a hold buffer.
//
// Ports:
//   clk, rst_n       core clock, asynchronous active-low reset
//   stall_i          hazard-unit freeze of PC and IF/ID
//   back_i, npc_i    redirect taken flag and target address
//   imem_en_o        BRAM read enable (registered, 1 from first edge after reset)
//   imem_addr_o      BRAM byte address (= pc_q)
//   imem_rdata_i     BRAM data, valid one cycle after the address
//   if_pc_o          PC of the presented instruction
//   if_pc4_o         if_pc_o + 4
//   if_inst_o        presented instruction (NOP_INST when not valid)
//   if_valid_o       presented instruction is on the correct path
//   redirect_cnt_o   saturating count of redirect edges
//   bubble_cnt_o     saturating count of edges presenting no valid instruction
//
// Optional feature: define FETCH_PERF_EN to build the two performance
// counters; otherwise both counter ports are tied to zero.

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        back_i,
  input  logic [31:0] npc_i,
  output logic        imem_en_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic [31:0] redirect_cnt_o,
  output logic [31:0] bubble_cnt_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              req_valid_q, req_valid_d;
  logic [XLEN-1:0]   hold_inst_q, hold_inst_d;
  logic              imem_en_q, imem_en_d;
  logic              adv;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      hold_inst_q <= NOP_INST;
      imem_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      hold_inst_q <= hold_inst_d;
      imem_en_q   <= imem_en_d;
    end
  end

  // Next-state: redirect beats stall beats advance
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    hold_inst_d = hold_inst_q;
    imem_en_d   = 1'b1;
    adv         = !stall_i && !back_i;

    if (back_i) begin
      pc_d        = {npc_i[XLEN-1:2], 2'b00};
      req_valid_d = 1'b0;
      hold_inst_d = NOP_INST;
      state_d     = S_FILL;
    end else if (stall_i) begin
      // Capture the BRAM word once; its read port moves on to pc_q.
      if (state_q == S_RUN) begin
        hold_inst_d = imem_rdata_i;
        state_d     = S_HOLD;
      end
    end else if (adv && (state_q != S_FILL || imem_en_q)) begin
      // Straight after reset the BRAM has not yet been enabled, so FILL
      // waits one edge before treating the read data as real.
      pc_d        = pc_q + XLEN'(4);
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      state_d     = S_RUN;
    end
  end

  // IF/ID presentation
  always_comb begin
    if_inst_o = NOP_INST;
    if (req_valid_q) begin
      case (state_q)
        S_RUN:   if_inst_o = imem_rdata_i;
        S_HOLD:  if_inst_o = hold_inst_q;
        default: if_inst_o = NOP_INST;
      endcase
    end
  end

  assign imem_en_o   = imem_en_q;
  assign imem_addr_o = pc_q;
  assign if_pc_o     = req_pc_q;
  assign if_pc4_o    = req_pc_q + XLEN'(4);
  assign if_valid_o  = req_valid_q;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] redirect_cnt_q, redirect_cnt_d;
  logic [XLEN-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= '0;
      bubble_cnt_q   <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    bubble_cnt_d   = bubble_cnt_q;
    if (back_i && (redirect_cnt_q != '1)) begin
      redirect_cnt_d = redirect_cnt_q + XLEN'(1);
    end
    if (!req_valid_q && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + XLEN'(1);
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
  assign bubble_cnt_o   = bubble_cnt_q;
`else
  assign redirect_cnt_o = '0;
  assign bubble_cnt_o   = '0;
`endif

endmodule
